// File: rtl/dcache_responder_pkg.sv
// Shared types for the dcache_responder slice.
// DCACHE_HITCNT_EN adds the CNT state and the hit/miss dump address.
package dcache_responder_pkg;

    localparam int DC_SETS  = 16;
    localparam int DC_IDX_W = $clog2(DC_SETS);
    localparam int DC_TAG_W = 30 - DC_IDX_W;

    typedef logic [31:0] word_t;

`ifdef DCACHE_HITCNT_EN
    localparam word_t HITCNT_ADDR = 32'h0000_3100;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        FILL  = 3'd2,
        FLUSH = 3'd3,
`ifdef DCACHE_HITCNT_EN
        CNT   = 3'd4,
`endif
        DONE  = 3'd5
    } dcache_state_t;

    typedef struct packed {
        logic [DC_TAG_W-1:0] tag;
        logic [DC_IDX_W-1:0] idx;
        logic [1:0]          bytoff;
    } dcachef_t;

endpackage

// File: rtl/dcache_responder_frame_array.sv
// Direct-mapped frame storage: valid/dirty/tag/data per set, synchronous write,
// asynchronous read, single index shared by read and write.
module dcache_responder_frame_array #(
    parameter int SETS   = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 26,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [IDX_W-1:0]  idx,
    input  logic              wr_en,
    input  logic              wr_valid,
    input  logic              wr_dirty,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [WORD_W-1:0] data_q [SETS];

    // Frame update; reset clears every frame.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (wr_en) begin
            valid_q[idx] <= wr_valid;
            dirty_q[idx] <= wr_dirty;
            tag_q[idx]   <= wr_tag;
            data_q[idx]  <= wr_data;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache responder with halt flush.
// Optional DCACHE_HITCNT_EN: hit/miss counters dumped to RAM after the flush.
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int SETS   = DC_SETS,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    input  logic              halt,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    output logic              flushed,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              dwait
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_W - 2 - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);
`ifdef DCACHE_HITCNT_EN
    localparam dcache_state_t AFTER_FLUSH = CNT;
`else
    localparam dcache_state_t AFTER_FLUSH = DONE;
`endif

    dcache_state_t    state_q, state_d;
    logic [IDX_W-1:0] flush_idx_q, flush_idx_d;
    logic             halt_pend_q, halt_pend_d;

    logic [IDX_W-1:0]  req_idx_s, idx_s;
    logic [TAG_W-1:0]  req_tag_s, rd_tag_s, wr_tag_s;
    logic [WORD_W-1:0] rd_data_s, wr_data_s;
    logic              rd_valid_s, rd_dirty_s, wr_en_s, wr_valid_s, wr_dirty_s;
    logic              hit_s, req_s, halt_req_s;

    assign req_idx_s  = daddr[2 +: IDX_W];
    assign req_tag_s  = daddr[WORD_W-1 -: TAG_W];
    assign idx_s      = (state_q == FLUSH) ? flush_idx_q : req_idx_s;
    assign hit_s      = rd_valid_s && (rd_tag_s == req_tag_s);
    assign req_s      = dREN || dWEN;
    // A halt that arrived mid-transfer is remembered until IDLE can act on it.
    assign halt_req_s = halt || halt_pend_q;

    dcache_responder_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .WORD_W(WORD_W)
    ) u_frames (
        .CLK     (CLK),
        .nRST    (nRST),
        .idx     (idx_s),
        .wr_en   (wr_en_s),
        .wr_valid(wr_valid_s),
        .wr_dirty(wr_dirty_s),
        .wr_tag  (wr_tag_s),
        .wr_data (wr_data_s),
        .rd_valid(rd_valid_s),
        .rd_dirty(rd_dirty_s),
        .rd_tag  (rd_tag_s),
        .rd_data (rd_data_s)
    );

`ifdef DCACHE_HITCNT_EN
    logic [WORD_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Hit counter saturates; a miss is counted once when IDLE leaves for WB or FILL.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (dhit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + WORD_W'(1);
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if ((state_q == IDLE) && ((state_d == WB) || (state_d == FILL))) begin
            miss_cnt_d = miss_cnt_q + WORD_W'(1);
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

    // Next-state, frame write and port decode.
    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        halt_pend_d = halt_pend_q;
        wr_en_s     = 1'b0;
        wr_valid_s  = rd_valid_s;
        wr_dirty_s  = rd_dirty_s;
        wr_tag_s    = rd_tag_s;
        wr_data_s   = rd_data_s;
        dhit        = 1'b0;
        dmemload    = '0;
        flushed     = 1'b0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state_q)
            IDLE: begin
                if (halt_req_s) begin
                    state_d     = FLUSH;
                    halt_pend_d = 1'b0;
                end else if (req_s && hit_s) begin
                    dhit = 1'b1;
                    if (dWEN) begin
                        wr_en_s    = 1'b1;
                        wr_valid_s = 1'b1;
                        wr_dirty_s = 1'b1;
                        wr_data_s  = dstore;
                    end else begin
                        dmemload = rd_data_s;
                    end
                end else if (req_s) begin
                    state_d = (rd_valid_s && rd_dirty_s) ? WB : FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            WB: begin
                halt_pend_d = halt_pend_q || halt;
                ramWEN      = 1'b1;
                ramaddr     = {rd_tag_s, req_idx_s, 2'b00};
                ramstore    = rd_data_s;
                if (!dwait) begin
                    state_d = FILL;
                end else begin
                    state_d = WB;
                end
            end
            FILL: begin
                halt_pend_d = halt_pend_q || halt;
                ramREN      = 1'b1;
                ramaddr     = daddr;
                if (!dwait) begin
                    wr_en_s    = 1'b1;
                    wr_valid_s = 1'b1;
                    wr_dirty_s = 1'b0;
                    wr_tag_s   = req_tag_s;
                    wr_data_s  = ramload;
                    state_d    = IDLE;
                end else begin
                    state_d = FILL;
                end
            end
            FLUSH: begin
                halt_pend_d = 1'b0;
                if (rd_dirty_s) begin
                    ramWEN   = 1'b1;
                    ramaddr  = {rd_tag_s, flush_idx_q, 2'b00};
                    ramstore = rd_data_s;
                end else begin
                    ramWEN = 1'b0;
                end
                // Clean frames advance immediately; dirty ones wait for the RAM.
                if (!rd_dirty_s || !dwait) begin
                    wr_en_s     = rd_dirty_s;
                    wr_dirty_s  = 1'b0;
                    flush_idx_d = flush_idx_q + IDX_W'(1);
                    state_d     = (flush_idx_q == LAST_IDX) ? AFTER_FLUSH : FLUSH;
                end else begin
                    state_d = FLUSH;
                end
            end
`ifdef DCACHE_HITCNT_EN
            CNT: begin
                ramWEN   = 1'b1;
                ramaddr  = HITCNT_ADDR;
                ramstore = hit_cnt_q - miss_cnt_q;
                state_d  = dwait ? CNT : DONE;
            end
`endif
            DONE: begin
                flushed = 1'b1;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            flush_idx_q <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
            halt_pend_q <= halt_pend_d;
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: flat-memory + direct-mapped reference model.
module tb_dcache_responder;

    logic        CLK = 1'b0;
    logic        nRST, dREN, dWEN, halt, dwait;
    logic        dhit, flushed, ramREN, ramWEN;
    logic [31:0] daddr, dstore, dmemload, ramaddr, ramstore, ramload;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];
    bit          rv   [16];
    bit          rdty [16];
    logic [25:0] rt   [16];
    int          n_acc, n_miss, ram_act, n_rd;
    logic [31:0] last_rd_addr;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always #5 CLK = ~CLK;

    dcache_responder dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed), .ramREN(ramREN),
        .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .dwait(dwait)
    );

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (a < 32'h400) return ram[a[9:2]];
        return 32'h0;
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
        for (int i = 0; i < 16; i++) begin rv[i] = 1'b0; rdty[i] = 1'b0; rt[i] = '0; end
        n_acc = 0; n_miss = 0;
    endtask

    // One RAM-side cycle at the negedge: observe strobes, pick dwait, commit completed writes.
    task automatic service(input int mode);
        checks++;
        if (ramREN && ramWEN) begin failures++; $display("FAIL strobe_excl ren=%0b wen=%0b exp=not_both", ramREN, ramWEN); end
        if (ramREN || ramWEN) ram_act++;
        dwait = (mode == 2) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
        ramload = ram_rd(ramaddr);
        if (ramWEN && !dwait) begin
            wr_addr_q.push_back(ramaddr); wr_data_q.push_back(ramstore);
            if (ramaddr < 32'h400) ram[ramaddr[9:2]] = ramstore;
            else if (ramaddr != 32'h3100) begin
                checks++; failures++; $display("FAIL wr_range addr=%h exp=<0x400", ramaddr);
            end
        end
        if (ramREN && !dwait) begin n_rd++; last_rd_addr = ramaddr; end
    endtask

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int mode, output int lat, output logic [31:0] rd);
        bit done = 1'b0;
        int cyc = 0;
        dREN = !wr; dWEN = wr; daddr = addr; dstore = wd;
        lat = -1; rd = '0;
        while (!done && cyc < 100) begin
            @(negedge CLK);
            if (dhit) begin done = 1'b1; lat = cyc; rd = dmemload; end
            service(mode);
            cyc++;
        end
        @(posedge CLK); #1;
        dREN = 1'b0; dWEN = 1'b0; dwait = 1'b0;
        if (!done) begin checks++; failures++; $display("FAIL access_timeout addr=%h got=no_dhit exp=dhit", addr); end
    endtask

    task automatic ref_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input int mode);
        int idx, lat;
        logic [25:0] tag;
        logic [31:0] rd, vaddr;
        bit eh, ev;
        idx = int'(addr[5:2]); tag = addr[31:6];
        eh = rv[idx] && (rt[idx] == tag);
        ev = !eh && rv[idx] && rdty[idx];
        vaddr = {rt[idx], idx[3:0], 2'b00};
        wr_addr_q.delete(); wr_data_q.delete(); ram_act = 0;
        access(wr, addr, wd, mode, lat, rd);
        checks++;
        if ((lat == 0) != eh) begin failures++; $display("FAIL hit_timing addr=%h lat=%0d exp_hit=%0b", addr, lat, eh); end
        if (!eh && mode == 0) begin
            checks++;
            if (lat != (ev ? 3 : 2)) begin failures++; $display("FAIL miss_latency addr=%h got=%0d exp=%0d", addr, lat, ev ? 3 : 2); end
        end
        checks++;
        if (wr_addr_q.size() != (ev ? 1 : 0)) begin failures++; $display("FAIL wb_count addr=%h got=%0d exp=%0d", addr, wr_addr_q.size(), ev ? 1 : 0); end
        else if (ev) begin
            checks++;
            if (wr_addr_q[0] !== vaddr || wr_data_q[0] !== ref_mem[vaddr[9:2]]) begin
                failures++; $display("FAIL wb_victim got=%h/%h exp=%h/%h", wr_addr_q[0], wr_data_q[0], vaddr, ref_mem[vaddr[9:2]]);
            end
        end
        if (eh) begin
            checks++;
            if (ram_act != 0) begin failures++; $display("FAIL hit_no_ram addr=%h got=%0d exp=0", addr, ram_act); end
        end
        if (!wr) begin
            checks++;
            if (rd !== ref_mem[addr[9:2]]) begin failures++; $display("FAIL read_data addr=%h got=%h exp=%h", addr, rd, ref_mem[addr[9:2]]); end
        end
        n_acc++;
        if (!eh) n_miss++;
        rv[idx] = 1'b1; rt[idx] = tag;
        if (wr) begin ref_mem[addr[9:2]] = wd; rdty[idx] = 1'b1; end
        else if (!eh) rdty[idx] = 1'b0;
    endtask

    task automatic reset_dut;
        nRST = 1'b0; halt = 1'b0; dREN = 1'b0; dWEN = 1'b0; dwait = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1'b1;
        model_reset();
    endtask

    task automatic run_flush;
        int cyc = 0;
        wr_addr_q.delete(); wr_data_q.delete();
        halt = 1'b1;
        while (cyc < 400) begin
            @(negedge CLK);
            if (flushed) break;
            service(1);
            cyc++;
        end
        checks++;
        if (!flushed) begin failures++; $display("FAIL flush_timeout got=%0b exp=1", flushed); end
        @(posedge CLK); #1;
        dwait = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b0; halt = 1'b0; dREN = 1'b0; dWEN = 1'b0; dwait = 1'b0;
        daddr = '0; dstore = '0; ramload = '0;
        @(posedge CLK); @(negedge CLK);
        checks++;
        if ({dhit, flushed, ramREN, ramWEN} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {dhit, flushed, ramREN, ramWEN}); end
        checks++;
        if (dmemload !== 32'h0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            failures++; $display("FAIL reset_buses got=%h/%h/%h exp=0", dmemload, ramaddr, ramstore);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        model_reset();
    endtask

    task automatic test_cold_read;
        int rd0;
        rd0 = n_rd;
        ref_access(1'b0, 32'h40, 32'h0, 0);
        checks++;
        if (n_rd - rd0 != 1 || last_rd_addr !== 32'h40) begin failures++; $display("FAIL cold_fill got=%0d@%h exp=1@00000040", n_rd - rd0, last_rd_addr); end
        rd0 = n_rd;
        ref_access(1'b0, 32'h40, 32'h0, 0);
        checks++;
        if (n_rd != rd0) begin failures++; $display("FAIL repeat_no_ren got=%0d exp=0", n_rd - rd0); end
    endtask

    task automatic test_write_hit;
        ref_access(1'b1, 32'h40, 32'h1234, 0);
    endtask

    task automatic test_conflict;
        ref_access(1'b0, 32'h80, 32'h0, 0);
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h40 || wr_data_q[0] !== 32'h1234) begin
            failures++; $display("FAIL conflict_wb got_n=%0d exp=1 at 00000040 data 00001234", wr_addr_q.size());
        end
    endtask

    task automatic test_dwait_fill;
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h44;
        @(negedge CLK);
        checks++;
        if (dhit !== 1'b0) begin failures++; $display("FAIL dwait_miss_dhit got=%b exp=0", dhit); end
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            checks++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h44 || dhit !== 1'b0) begin
                failures++; $display("FAIL dwait_hold cyc=%0d got=%b/%h/%b exp=1/00000044/0", i, ramREN, ramaddr, dhit);
            end
            dwait = (i <= 5); ramload = ram_rd(ramaddr);
        end
        @(negedge CLK);
        checks++;
        if (dhit !== 1'b1 || dmemload !== ref_mem[17]) begin failures++; $display("FAIL dwait_result got=%b/%h exp=1/%h", dhit, dmemload, ref_mem[17]); end
        @(posedge CLK); #1;
        dREN = 1'b0; dwait = 1'b0;
        rv[1] = 1'b1; rt[1] = 26'd1; rdty[1] = 1'b0; n_acc++; n_miss++;
    endtask

    task automatic test_flush;
        int expw;
        ref_access(1'b1, 32'h40, 32'hA5A5_0001, 0);
        ref_access(1'b1, 32'h7C, 32'h5A5A_000F, 0);
        run_flush();
`ifdef DCACHE_HITCNT_EN
        expw = 3;
`else
        expw = 2;
`endif
        checks++;
        if (wr_addr_q.size() != expw) begin failures++; $display("FAIL flush_count got=%0d exp=%0d", wr_addr_q.size(), expw); end
        else begin
            checks++;
            if (wr_addr_q[0] !== 32'h40 || wr_addr_q[1] !== 32'h7C) begin failures++; $display("FAIL flush_addrs got=%h,%h exp=00000040,0000007c", wr_addr_q[0], wr_addr_q[1]); end
`ifdef DCACHE_HITCNT_EN
            checks++;
            if (wr_addr_q[2] !== 32'h3100 || wr_data_q[2] !== 32'(n_acc - n_miss)) begin
                failures++; $display("FAIL hitcnt_dump got=%h@%h exp=%h@00003100", wr_data_q[2], wr_addr_q[2], 32'(n_acc - n_miss));
            end
`endif
        end
        checks++;
        if (ram[16] !== ref_mem[16] || ram[31] !== ref_mem[31]) begin failures++; $display("FAIL flush_data got=%h,%h exp=%h,%h", ram[16], ram[31], ref_mem[16], ref_mem[31]); end
        dREN = 1'b1; daddr = 32'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if ({flushed, dhit, ramREN, ramWEN} !== 4'b1000) begin failures++; $display("FAIL done_sticky got=%b exp=1000", {flushed, dhit, ramREN, ramWEN}); end
        end
        @(posedge CLK); #1;
        dREN = 1'b0;
    endtask

    task automatic test_reset_mid_wb;
        reset_dut();
        ref_access(1'b1, 32'h40, 32'hCAFE_F00D, 0);
        dREN = 1'b1; daddr = 32'h80; dwait = 1'b1;
        @(negedge CLK);
        checks++;
        if (ramWEN !== 1'b0) begin failures++; $display("FAIL pre_wb got=%b exp=0", ramWEN); end
        @(negedge CLK);
        checks++;
        if (ramWEN !== 1'b1 || ramaddr !== 32'h40) begin failures++; $display("FAIL in_wb got=%b/%h exp=1/00000040", ramWEN, ramaddr); end
        @(posedge CLK); #1;
        nRST = 1'b0;
        @(posedge CLK); @(negedge CLK);
        checks++;
        if ({ramWEN, ramREN, dhit} !== 3'b000) begin failures++; $display("FAIL wb_abort got=%b exp=000", {ramWEN, ramREN, dhit}); end
        @(posedge CLK); #1;
        nRST = 1'b1; dREN = 1'b0; dwait = 1'b0;
        model_reset();
        ref_access(1'b0, 32'h40, 32'h0, 0);
    endtask

    task automatic test_random;
        int bad = 0;
        reset_dut();
        for (int i = 0; i < 80; i++) begin
            ref_access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, $urandom, 1);
        end
        run_flush();
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL random_ram_image got=%0d_bad_words exp=0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        ram[16] = 32'hDEAD_BEEF;
        test_reset();
        test_cold_read();
        test_write_hit();
        test_conflict();
        test_dwait_fill();
        test_flush();
        test_reset_mid_wb();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
